// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between the IF fetch port and the MEM data port.
// Registered request/ready bus towards memory, combinational stall to the CPU, watchdog abort of hung transfers.
module memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_request,
    input  logic [31:0] if_address,
    output logic [31:0] if_read_data,
    output logic        if_ready,

    input  logic        mem_request,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_select,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,

    output logic        bus_request,
    output logic        bus_write_enable,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_select,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ready,

    output logic        bus_error,
    output logic        stall_request
);

    localparam int unsigned CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic        TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic        GRANT_IF     = 1'b0;
    localparam logic        GRANT_MEM    = 1'b1;
    localparam logic [3:0]  FETCH_SELECT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE_IF  = 2'd1,
        ST_SERVE_MEM = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    typedef struct packed {
        logic        write_enable;
        logic [31:0] address;
        logic [31:0] write_data;
        logic [3:0]  select;
    } bus_cmd_t;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_q, count_d;
    bus_cmd_t         bus_cmd_q, bus_cmd_d;
    logic             bus_request_q, bus_request_d;
    logic [31:0]      if_read_data_q, if_read_data_d;
    logic             if_ready_q, if_ready_d;
    logic [31:0]      mem_read_data_q, mem_read_data_d;
    logic             mem_ready_q, mem_ready_d;
    logic             bus_error_q, bus_error_d;

    logic             grant_mem_c;
    logic             grant_if_c;
    logic             timeout_c;

    // On a tie the requester that did not win last time gets the bus.
    assign grant_mem_c = mem_request & (~if_request | (last_grant_q == GRANT_IF));
    assign grant_if_c  = if_request & ~grant_mem_c;
    assign timeout_c   = TIMEOUT_EN & (count_q == CNT_W'(TIMEOUT_LAST));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_mem_c) begin
                    state_d = ST_SERVE_MEM;
                end else if (grant_if_c) begin
                    state_d = ST_SERVE_IF;
                end
            end
            ST_SERVE_IF, ST_SERVE_MEM: begin
                if (bus_ready || timeout_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; ready and error pulses default low
    always_comb begin
        last_grant_d    = last_grant_q;
        count_d         = count_q;
        bus_cmd_d       = bus_cmd_q;
        bus_request_d   = bus_request_q;
        if_read_data_d  = if_read_data_q;
        mem_read_data_d = mem_read_data_q;
        if_ready_d      = 1'b0;
        mem_ready_d     = 1'b0;
        bus_error_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_mem_c) begin
                    bus_cmd_d     = '{write_enable: mem_write_enable, address: mem_address,
                                      write_data: mem_write_data, select: mem_select};
                    bus_request_d = 1'b1;
                    last_grant_d  = GRANT_MEM;
                    count_d       = '0;
                end else if (grant_if_c) begin
                    bus_cmd_d     = '{write_enable: 1'b0, address: if_address,
                                      write_data: 32'h0, select: FETCH_SELECT};
                    bus_request_d = 1'b1;
                    last_grant_d  = GRANT_IF;
                    count_d       = '0;
                end
            end
            ST_SERVE_IF: begin
                if (bus_ready) begin
                    if_read_data_d = bus_read_data;
                    if_ready_d     = 1'b1;
                    bus_request_d  = 1'b0;
                end else if (timeout_c) begin
                    if_read_data_d = 32'h0;
                    if_ready_d     = 1'b1;
                    bus_error_d    = 1'b1;
                    bus_request_d  = 1'b0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_SERVE_MEM: begin
                if (bus_ready) begin
                    if (!bus_cmd_q.write_enable) begin
                        mem_read_data_d = bus_read_data;
                    end
                    mem_ready_d   = 1'b1;
                    bus_request_d = 1'b0;
                end else if (timeout_c) begin
                    mem_read_data_d = 32'h0;
                    mem_ready_d     = 1'b1;
                    bus_error_d     = 1'b1;
                    bus_request_d   = 1'b0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q    <= GRANT_IF;
            count_q         <= '0;
            bus_cmd_q       <= '0;
            bus_request_q   <= 1'b0;
            if_read_data_q  <= 32'h0;
            if_ready_q      <= 1'b0;
            mem_read_data_q <= 32'h0;
            mem_ready_q     <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            last_grant_q    <= last_grant_d;
            count_q         <= count_d;
            bus_cmd_q       <= bus_cmd_d;
            bus_request_q   <= bus_request_d;
            if_read_data_q  <= if_read_data_d;
            if_ready_q      <= if_ready_d;
            mem_read_data_q <= mem_read_data_d;
            mem_ready_q     <= mem_ready_d;
            bus_error_q     <= bus_error_d;
        end
    end

    assign bus_request      = bus_request_q;
    assign bus_write_enable = bus_cmd_q.write_enable;
    assign bus_address      = bus_cmd_q.address;
    assign bus_write_data   = bus_cmd_q.write_data;
    assign bus_select       = bus_cmd_q.select;
    assign if_read_data     = if_read_data_q;
    assign if_ready         = if_ready_q;
    assign mem_read_data    = mem_read_data_q;
    assign mem_ready        = mem_ready_q;
    assign bus_error        = bus_error_q;
    assign stall_request    = (if_request & ~if_ready_q) | (mem_request & ~mem_ready_q);

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: two instances (watchdog 16 and 4) against a transaction-timing reference model.
module tb_memory_arbiter;

    localparam int NUM_CYCLES    = 3000;
    localparam int CONTEND_UNTIL = 200;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Per-instance stimulus (index 0: watchdog 16, index 1: watchdog 4)
    logic        reset [2];
    logic        if_request [2];
    logic [31:0] if_address [2];
    logic        mem_request [2];
    logic        mem_write_enable [2];
    logic [31:0] mem_address [2];
    logic [31:0] mem_write_data [2];
    logic [3:0]  mem_select [2];
    logic [31:0] bus_read_data [2];
    logic        bus_ready [2];

    logic [31:0] if_read_data [2];
    logic        if_ready [2];
    logic [31:0] mem_read_data [2];
    logic        mem_ready [2];
    logic        bus_request [2];
    logic        bus_write_enable [2];
    logic [31:0] bus_address [2];
    logic [31:0] bus_write_data [2];
    logic [3:0]  bus_select [2];
    logic        bus_error [2];
    logic        stall_request [2];

    memory_arbiter #(.TIMEOUT_CYCLES(16)) u_dut_t16 (
        .clock(clock), .reset(reset[0]),
        .if_request(if_request[0]), .if_address(if_address[0]),
        .if_read_data(if_read_data[0]), .if_ready(if_ready[0]),
        .mem_request(mem_request[0]), .mem_write_enable(mem_write_enable[0]),
        .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
        .mem_select(mem_select[0]), .mem_read_data(mem_read_data[0]), .mem_ready(mem_ready[0]),
        .bus_request(bus_request[0]), .bus_write_enable(bus_write_enable[0]),
        .bus_address(bus_address[0]), .bus_write_data(bus_write_data[0]),
        .bus_select(bus_select[0]), .bus_read_data(bus_read_data[0]), .bus_ready(bus_ready[0]),
        .bus_error(bus_error[0]), .stall_request(stall_request[0])
    );

    memory_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_t4 (
        .clock(clock), .reset(reset[1]),
        .if_request(if_request[1]), .if_address(if_address[1]),
        .if_read_data(if_read_data[1]), .if_ready(if_ready[1]),
        .mem_request(mem_request[1]), .mem_write_enable(mem_write_enable[1]),
        .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
        .mem_select(mem_select[1]), .mem_read_data(mem_read_data[1]), .mem_ready(mem_ready[1]),
        .bus_request(bus_request[1]), .bus_write_enable(bus_write_enable[1]),
        .bus_address(bus_address[1]), .bus_write_data(bus_write_data[1]),
        .bus_select(bus_select[1]), .bus_read_data(bus_read_data[1]), .bus_ready(bus_ready[1]),
        .bus_error(bus_error[1]), .stall_request(stall_request[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int timeout_of(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    // Reference model: one record per transaction, outputs derived from the grant cycle and wait count
    bit          busy [2];
    bit          who_mem [2];
    bit          aborts [2];
    bit          last_mem [2];
    bit          first_tx [2];
    int          g_cyc [2];
    int          span [2];
    int          rdy_cyc [2];
    int          idle_from [2];
    logic [31:0] x_rdata [2];
    logic        e_we [2];
    logic [31:0] e_addr [2];
    logic [31:0] e_wd [2];
    logic [3:0]  e_sel [2];
    logic [31:0] e_if_rd [2];
    logic [31:0] e_mem_rd [2];

    // Next-cycle stimulus
    logic        n_reset [2];
    logic        n_ifreq [2];
    logic [31:0] n_ifaddr [2];
    logic        n_memreq [2];
    logic        n_we [2];
    logic [31:0] n_maddr [2];
    logic [31:0] n_wd [2];
    logic [3:0]  n_sel [2];
    logic        n_bready [2];
    logic [31:0] n_brdata [2];

    task automatic new_fetch(input int u);
        n_ifreq[u]  = 1'b1;
        n_ifaddr[u] = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_data(input int u);
        n_memreq[u] = 1'b1;
        n_we[u]     = 1'($urandom_range(0, 1));
        n_maddr[u]  = $urandom & 32'hFFFF_FFFC;
        n_wd[u]     = $urandom;
        n_sel[u]    = 4'($urandom_range(1, 15));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            busy[u] = 1'b0; who_mem[u] = 1'b0; aborts[u] = 1'b0; last_mem[u] = 1'b0;
            first_tx[u] = 1'b1; g_cyc[u] = 0; span[u] = 0; rdy_cyc[u] = -1; idle_from[u] = 0;
            x_rdata[u] = 32'h0; e_we[u] = 1'b0; e_addr[u] = 32'h0; e_wd[u] = 32'h0;
            e_sel[u] = 4'h0; e_if_rd[u] = 32'h0; e_mem_rd[u] = 32'h0;
            n_reset[u] = 1'b1; n_ifreq[u] = 1'b0; n_ifaddr[u] = 32'h0; n_memreq[u] = 1'b0;
            n_we[u] = 1'b0; n_maddr[u] = 32'h0; n_wd[u] = 32'h0; n_sel[u] = 4'h0;
            n_bready[u] = 1'b0; n_brdata[u] = 32'h0;
            reset[u] = 1'b1; if_request[u] = 1'b0; if_address[u] = 32'h0; mem_request[u] = 1'b0;
            mem_write_enable[u] = 1'b0; mem_address[u] = 32'h0; mem_write_data[u] = 32'h0;
            mem_select[u] = 4'h0; bus_ready[u] = 1'b0; bus_read_data[u] = 32'h0;
        end
        repeat (2) @(posedge clock);

        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(posedge clock);
            #1;
            for (int u = 0; u < 2; u++) begin
                reset[u]            = n_reset[u];
                if_request[u]       = n_ifreq[u];
                if_address[u]       = n_ifaddr[u];
                mem_request[u]      = n_memreq[u];
                mem_write_enable[u] = n_we[u];
                mem_address[u]      = n_maddr[u];
                mem_write_data[u]   = n_wd[u];
                mem_select[u]       = n_sel[u];
                bus_ready[u]        = n_bready[u];
                bus_read_data[u]    = n_brdata[u];
            end
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                int  done;
                int  w;
                bit  e_breq, e_ifr, e_memr, e_err, contend, win_next;
                string pfx;
                pfx     = $sformatf("u%0d c%0d", u, c);
                done    = g_cyc[u] + 1 + span[u];
                e_breq  = busy[u] && (c >= g_cyc[u] + 1) && (c <= g_cyc[u] + span[u]);
                e_ifr   = busy[u] && (c == done) && !who_mem[u];
                e_memr  = busy[u] && (c == done) && who_mem[u];
                e_err   = busy[u] && (c == done) && aborts[u];

                check({pfx, " bus_request"},      32'(bus_request[u]),      32'(e_breq));
                check({pfx, " bus_write_enable"}, 32'(bus_write_enable[u]), 32'(e_we[u]));
                check({pfx, " bus_address"},      bus_address[u],           e_addr[u]);
                check({pfx, " bus_write_data"},   bus_write_data[u],        e_wd[u]);
                check({pfx, " bus_select"},       32'(bus_select[u]),       32'(e_sel[u]));
                check({pfx, " if_ready"},         32'(if_ready[u]),         32'(e_ifr));
                check({pfx, " mem_ready"},        32'(mem_ready[u]),        32'(e_memr));
                check({pfx, " bus_error"},        32'(bus_error[u]),        32'(e_err));
                check({pfx, " if_read_data"},     if_read_data[u],          e_if_rd[u]);
                check({pfx, " mem_read_data"},    mem_read_data[u],         e_mem_rd[u]);
                check({pfx, " stall_request"},    32'(stall_request[u]),
                      32'((if_request[u] && !e_ifr) || (mem_request[u] && !e_memr)));

                // Requesters: hold until ready, then drop or issue a fresh request
                contend = (c < CONTEND_UNTIL);
                if (e_ifr) begin
                    n_ifreq[u] = 1'b0;
                    if (contend || $urandom_range(0, 99) < 40) new_fetch(u);
                end else if (!n_ifreq[u] && (contend || $urandom_range(0, 99) < 30)) begin
                    new_fetch(u);
                end
                if (e_memr) begin
                    n_memreq[u] = 1'b0;
                    if (contend || $urandom_range(0, 99) < 40) new_data(u);
                end else if (!n_memreq[u] && (contend || $urandom_range(0, 99) < 30)) begin
                    new_data(u);
                end
                // First cycle out of reset: a tied write vs fetch on unit 0, a lone fetch on unit 1
                if (c == 1) begin
                    n_ifreq[u]  = 1'b1;
                    n_ifaddr[u] = 32'h0000_0004;
                    n_memreq[u] = (u == 0);
                    n_we[u]     = 1'b1;
                    n_maddr[u]  = 32'h0000_0100;
                    n_wd[u]     = 32'hDEAD_BEEF;
                    n_sel[u]    = 4'b0011;
                end

                // Arbiter decision at the end of this cycle
                if (reset[u]) begin
                    busy[u] = 1'b0; last_mem[u] = 1'b0; idle_from[u] = c + 1;
                    e_we[u] = 1'b0; e_addr[u] = 32'h0; e_wd[u] = 32'h0; e_sel[u] = 4'h0;
                    e_if_rd[u] = 32'h0; e_mem_rd[u] = 32'h0;
                end else begin
                    if (busy[u] && c == g_cyc[u] + span[u]) begin
                        if (aborts[u]) begin
                            if (who_mem[u]) e_mem_rd[u] = 32'h0;
                            else            e_if_rd[u]  = 32'h0;
                        end else if (!who_mem[u]) begin
                            e_if_rd[u] = x_rdata[u];
                        end else if (!e_we[u]) begin
                            e_mem_rd[u] = x_rdata[u];
                        end
                    end
                    if (c >= idle_from[u] && (if_request[u] || mem_request[u])) begin
                        who_mem[u] = (if_request[u] && mem_request[u]) ? !last_mem[u] : mem_request[u];
                        if (first_tx[u])                        w = 0;
                        else if (u == 0 && $urandom_range(0, 9) == 0) w = $urandom_range(16, 18);
                        else                                    w = $urandom_range(0, 6);
                        aborts[u]  = (w >= timeout_of(u));
                        span[u]    = aborts[u] ? timeout_of(u) : w + 1;
                        g_cyc[u]   = c;
                        rdy_cyc[u] = c + 1 + w;
                        x_rdata[u] = (first_tx[u] && u == 1) ? 32'h3C01_0101 : $urandom;
                        e_we[u]    = who_mem[u] ? mem_write_enable[u] : 1'b0;
                        e_addr[u]  = who_mem[u] ? mem_address[u] : if_address[u];
                        e_wd[u]    = who_mem[u] ? mem_write_data[u] : 32'h0;
                        e_sel[u]   = who_mem[u] ? mem_select[u] : 4'b1111;
                        last_mem[u]  = who_mem[u];
                        idle_from[u] = c + span[u] + 2;
                        busy[u]      = 1'b1;
                        first_tx[u]  = 1'b0;
                    end
                end

                // Memory: completes on schedule, otherwise random bus_ready noise outside a service window
                win_next     = busy[u] && (c + 1 >= g_cyc[u] + 1) && (c + 1 <= g_cyc[u] + span[u]);
                n_bready[u]  = busy[u] && (c + 1 == rdy_cyc[u]);
                n_brdata[u]  = n_bready[u] ? x_rdata[u] : $urandom;
                if (!n_bready[u] && !win_next) n_bready[u] = ($urandom_range(0, 3) == 0);

                // Resets: initial pulse, plus occasional ones mid-transaction later on
                n_reset[u] = (c + 1 < 2);
                if (c >= CONTEND_UNTIL) begin
                    if (win_next && who_mem[u] && $urandom_range(0, 24) == 0) n_reset[u] = 1'b1;
                    if ($urandom_range(0, 299) == 0) n_reset[u] = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
